// File: rtl/puf_challenge_seq.sv
// puf_challenge_seq -- drives LFSR-derived challenges to a PUF and returns
// each challenge/response pair through a valid/ready output port.
//
// Each run issues NUM_CHAL challenges. Before a challenge is issued, its
// parity is forced to differ from the previous challenge. This guarantees
// that the value on `challenge` always changes, so the PUF always starts
// a new evaluation. `challenge` keeps its value between runs so this
// parity rule also holds across run boundaries.
//
// Optional feature: define PUF_SEQ_TIMEOUT_EN to add a watchdog. When it
// is enabled, a run that waits TIMEOUT_CYCLES cycles for the PUF sets the
// sticky `err` flag and ends. When it is not defined, `err` is tied low
// and the sequencer waits for the PUF indefinitely.
//
// Reset is asynchronous and active-high.
module puf_challenge_seq #(
  parameter int NUM_CHAL       = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic       count_clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] seed,
  output logic [7:0] challenge,
  input  logic       puf_done,
  input  logic [7:0] puf_response,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [7:0] resp_data,
  output logic [7:0] resp_challenge,
  output logic [7:0] resp_idx,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // Reject parameter values that the 8-bit index or the counter cannot represent.
  if (NUM_CHAL < 1 || NUM_CHAL > 255) begin : g_bad_num_chal
    $error("puf_challenge_seq: NUM_CHAL must be in 1..255");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("puf_challenge_seq: TIMEOUT_CYCLES must be >= 1");
  end

  localparam logic [7:0] LAST_IDX = 8'(NUM_CHAL - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    OUTPUT    = 3'd4,
    FINISH    = 3'd5
  } state_t;

  state_t     state, state_next;
  logic       puf_sync1, puf_sync2;
  logic [7:0] lfsr;
  logic [7:0] lfsr_next;
  logic [7:0] chal_cand;
  logic       timeout_hit;

  // Bring the asynchronous puf_done flag into the count_clk domain.
  always_ff @(posedge count_clk or posedge reset) begin
    // NOTE: flops take non-blocking (<=) assignments, so every flop samples
    // values from before the clock edge, regardless of statement order.
    if (reset) begin
      puf_sync1 <= 1'b0;
      puf_sync2 <= 1'b0;
    end else begin
      puf_sync1 <= puf_done;
      puf_sync2 <= puf_sync1;
    end
  end

  // Compute the next LFSR value: shift left, and feed taps 7,5,4,3 back into bit 0.
  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  // Compute the candidate challenge: flip bit 0 when the LFSR value has the
  // same parity as the current challenge, so that the PUF always sees a
  // different value.
  assign chal_cand = lfsr ^ {7'b0, ~((^lfsr) ^ (^challenge))};

  assign busy = (state != IDLE);
  assign done = (state == FINISH);

`ifdef PUF_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  assign timeout_hit = ((state == WAIT_BUSY) || (state == WAIT_DONE)) &&
                       (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Run the watchdog. The counter clears on entry to WAIT_BUSY and counts
  // while the sequencer waits for the PUF. err is sticky until the next
  // accepted start.
  always_ff @(posedge count_clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE:      if (start) err <= 1'b0;
        ISSUE:     tmo_cnt <= '0;
        WAIT_BUSY,
        WAIT_DONE: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (timeout_hit) err <= 1'b1;
        end
        default:   ;
      endcase
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge count_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    // NOTE: assign a default before the case statement, so that no path
    // leaves state_next unassigned and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:      if (start) state_next = ISSUE;
      ISSUE:     state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (timeout_hit)     state_next = FINISH;
        else if (!puf_sync2) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (timeout_hit)     state_next = FINISH;
        else if (puf_sync2)  state_next = OUTPUT;
      end
      OUTPUT: begin
        if (resp_ready) state_next = (resp_idx == LAST_IDX) ? FINISH : ISSUE;
      end
      FINISH:    state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Datapath registers: LFSR, challenge, captured response pair and index.
  always_ff @(posedge count_clk or posedge reset) begin
    if (reset) begin
      lfsr           <= 8'h01;
      challenge      <= 8'h00;
      resp_valid     <= 1'b0;
      resp_data      <= 8'h00;
      resp_challenge <= 8'h00;
      resp_idx       <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            lfsr     <= (seed == 8'h00) ? 8'h01 : seed;
            resp_idx <= 8'h00;
          end
        end
        ISSUE: begin
          challenge <= chal_cand;
          lfsr      <= lfsr_next;
        end
        WAIT_DONE: begin
          if (puf_sync2 && !timeout_hit) begin
            resp_data      <= puf_response;
            resp_challenge <= challenge;
            resp_valid     <= 1'b1;
          end
        end
        OUTPUT: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            if (resp_idx != LAST_IDX) resp_idx <= resp_idx + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/puf_challenge_seq.md
PUF_CHALLENGE_SEQ -- requirements
Module: puf_challenge_seq

Interface
REQ-001 Parameter NUM_CHAL, default 16, number of challenge/response pairs per run (legal range 1..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 1048576, watchdog limit in count_clk cycles (used only when PUF_SEQ_TIMEOUT_EN is defined).
REQ-003 count_clk  input  1  block clock.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  begin a run; sampled only in IDLE.
REQ-006 seed  input  8  LFSR seed, captured on accepted start.
REQ-007 challenge  output  8  challenge driven to the PUF.
REQ-008 puf_done  input  1  PUF done flag, asynchronous to count_clk.
REQ-009 puf_response  input  8  PUF response, stable while puf_done is high.
REQ-010 resp_valid  output  1  response pair available.
REQ-011 resp_ready  input  1  downstream accepts pair.
REQ-012 resp_data  output  8  captured response.
REQ-013 resp_challenge  output  8  challenge that produced resp_data.
REQ-014 resp_idx  output  8  pair index within the run, 0-based.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse at end of run.
REQ-017 err  output  1  sticky timeout flag.

Function
REQ-018 States SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, OUTPUT, FINISH.
REQ-019 puf_done SHALL pass a 2-flop synchronizer; all uses below refer to the synchronized value.
REQ-020 IDLE with start=1: lfsr <= seed (0x00 replaced by 0x01), resp_idx <= 0, err <= 0, go ISSUE; start outside IDLE is ignored.
REQ-021 ISSUE: candidate c = lfsr; if ^c equals ^challenge (current output), c = c XOR 0x01; challenge <= c; lfsr advances; go WAIT_BUSY (one cycle in ISSUE).
REQ-022 LFSR advance: shift left, new bit0 = b7^b5^b4^b3 of the old value.
REQ-023 The parity toggle in REQ-021 guarantees every issued challenge triggers a new PUF evaluation.
REQ-024 WAIT_BUSY: remain until puf_done=0, then go WAIT_DONE.
REQ-025 WAIT_DONE: on puf_done=1, resp_data <= puf_response, resp_challenge <= challenge, resp_valid <= 1, go OUTPUT.
REQ-026 OUTPUT: resp_valid, resp_data, resp_challenge, resp_idx held stable until resp_valid&resp_ready.
REQ-027 On handshake: resp_valid <= 0; if resp_idx == NUM_CHAL-1 go FINISH, else resp_idx <= resp_idx+1 and go ISSUE.
REQ-028 resp_ready=1 with resp_valid=0 SHALL have no effect.
REQ-029 FINISH: done=1 for exactly one cycle, then IDLE; start in FINISH cycle is ignored.
REQ-030 challenge SHALL hold its last value across runs (parity continuity for the next run).

Reset
REQ-031 reset SHALL force IDLE, challenge=0x00, lfsr=0x01, resp_valid=0, resp_data=0, resp_challenge=0, resp_idx=0, busy=0, done=0, err=0, synchronizer=0.
REQ-032 reset mid-run SHALL abort immediately with no done pulse and no partial resp_valid.

Configuration
REQ-033 Macro PUF_SEQ_TIMEOUT_EN defined: a cycle counter clears on entry to WAIT_BUSY, counts in WAIT_BUSY/WAIT_DONE; reaching TIMEOUT_CYCLES sets err=1 and goes FINISH (done pulses, no resp_valid).
REQ-034 Macro PUF_SEQ_TIMEOUT_EN undefined: no counter, err tied 0, WAIT_BUSY/WAIT_DONE wait indefinitely.

Verification
REQ-035 After reset, seed=0x01, start, PUF model toggles done -> challenges issued 0x01 then 0x03 (lfsr 0x02, parity flip).
REQ-036 seed=0x00, start -> first challenge 0x01, identical to seed=0x01 run.
REQ-037 NUM_CHAL=4, resp_ready=1 -> four pairs with resp_idx 0..3, then single done pulse, busy falls next cycle.
REQ-038 resp_ready held 0 for 50 cycles in OUTPUT -> resp_valid/resp_data/resp_idx unchanged, no new challenge issued.
REQ-039 Macro defined, TIMEOUT_CYCLES=100, puf_done stuck 1 -> err=1 and done pulse 100 cycles after WAIT_BUSY entry; next start clears err.
REQ-040 reset asserted in WAIT_DONE -> all outputs return to reset values within the reset cycle, no done pulse.
